// File: rtl/ahb_read_master.sv
// AHB-Lite master that turns single commands into SINGLE/INCR transfers and
// reports one response pulse per data beat, with error and wait-state watchdog handling.
module ahb_read_master #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        HCLK,
  input  logic        HRESTn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [2:0]  cmd_size,
  input  logic [2:0]  cmd_len,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_last,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic        HBURST,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  localparam int WW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            write_q, write_d;
  logic [2:0]      size_q, size_d;
  logic            burst_q, burst_d;
  logic [2:0]      len_q, len_d;
  logic [2:0]      beat_q, beat_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            ill_q, ill_d;
  logic            err_rsp_s;
  logic            timeout_s;
  logic [31:0]     incr_s;

  assign HADDR     = addr_q;
  assign HWRITE    = write_q;
  assign HSIZE     = size_q;
  assign HBURST    = burst_q;
  assign incr_s    = 32'd1 << size_q[1:0];
  assign timeout_s = (state_q != ST_IDLE) && (wait_q == WW'(WAIT_LIMIT));

  // Next-state, bus-phase and response decode
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    size_d    = size_q;
    burst_d   = burst_q;
    len_d     = len_q;
    beat_d    = beat_q;
    ill_d     = 1'b0;
    err_rsp_s = 1'b0;
    cmd_ready = (state_q == ST_IDLE) && !ill_q;
    HTRANS    = 2'b00;
    HWDATA    = 32'd0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_error = 1'b0;
    rsp_last  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        err_rsp_s = ill_q;
        if (cmd_valid && cmd_ready) begin
          if (cmd_size <= 3'b010) begin
            state_d = ST_ACTIVE;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            write_d = cmd_write;
            size_d  = cmd_size;
            len_d   = cmd_write ? 3'd0 : cmd_len;
            burst_d = !cmd_write && (cmd_len != 3'd0);
            beat_d  = 3'd0;
          end else begin
            ill_d = 1'b1;
          end
        end else begin
          ill_d = 1'b0;
        end
      end

      ST_ACTIVE: begin
        // An error response withdraws the pending address phase immediately
        if (timeout_s) begin
          err_rsp_s = 1'b1;
          state_d   = ST_IDLE;
        end else if (HRESP) begin
          if (HREADY) begin
            err_rsp_s = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          HTRANS = (beat_q == 3'd0) ? 2'b10 : 2'b11;
          if (HREADY) begin
            if (beat_q != 3'd0) begin
              rsp_valid = 1'b1;
              rsp_rdata = HRDATA;
            end else begin
              rsp_valid = 1'b0;
            end
            if (beat_q == len_q) begin
              state_d = ST_DRAIN;
            end else begin
              beat_d = beat_q + 3'd1;
              addr_d = addr_q + incr_s;
            end
          end else begin
            state_d = ST_ACTIVE;
          end
        end
      end

      ST_DRAIN: begin
        HWDATA = write_q ? wdata_q : 32'd0;
        if (timeout_s) begin
          err_rsp_s = 1'b1;
          state_d   = ST_IDLE;
        end else if (HREADY) begin
          state_d = ST_IDLE;
          if (HRESP) begin
            err_rsp_s = 1'b1;
          end else begin
            rsp_valid = 1'b1;
            rsp_rdata = HRDATA;
            rsp_last  = 1'b1;
          end
        end else if (HRESP) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_ERR: begin
        if (timeout_s || HREADY) begin
          err_rsp_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (err_rsp_s) begin
      rsp_valid = 1'b1;
      rsp_rdata = 32'd0;
      rsp_error = 1'b1;
      rsp_last  = 1'b1;
    end else begin
      rsp_error = 1'b0;
    end

    // Stall count spans ACTIVE/DRAIN/ERR and restarts on any completed cycle
    if ((state_q != ST_IDLE) && (state_d != ST_IDLE) && !HREADY) begin
      wait_d = wait_q + WW'(1);
    end else begin
      wait_d = '0;
    end
  end

  // State and command registers
  always_ff @(posedge HCLK or negedge HRESTn) begin
    if (!HRESTn) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      burst_q <= 1'b0;
      len_q   <= 3'd0;
      beat_q  <= 3'd0;
      wait_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      ill_q   <= ill_d;
    end
  end

endmodule
